// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the I/D memory bus arbiter:
//   - access size codes as carried on d_size / bus_size
//   - arbiter FSM state encoding (2-bit)
//   - misalignment helper used when a D access is granted
// Optional build macro used by the arbiter files: MEM_ARB_RR_EN
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10,
        ST_DONE = 2'b11
    } arb_state_e;

    // Halfwords need addr[0]=0, words need addr[1:0]=00; bytes never fault.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SIZE_H:  bad = addr_lo[0];
            SIZE_W:  bad = (addr_lo != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// -----------------------------------------------------------------------------
// mem_arbiter_arb_pick
// Winner select between the fetch (I) and load/store (D) requesters.
//   i_req, d_req : pending requests
//   pick_d       : 1 = D wins, 0 = I wins (meaningful when a request exists)
// Build option MEM_ARB_RR_EN:
//   defined   - round-robin on simultaneous requests; a 1-bit pointer favours
//               the requester not granted last. Extra ports clk, resetn and
//               grant (pulse when the arbiter accepts a request).
//   undefined - fixed D-over-I priority, purely combinational.
// -----------------------------------------------------------------------------
module mem_arbiter_arb_pick (
`ifdef MEM_ARB_RR_EN
    input  logic clk,
    input  logic resetn,
    input  logic grant,
`endif
    input  logic i_req,
    input  logic d_req,
    output logic pick_d
);

`ifdef MEM_ARB_RR_EN
    logic favour_i_r;

    // Winner select: pointer only matters when both requesters are active.
    always_comb begin
        pick_d = 1'b0;
        if (i_req && d_req) begin
            pick_d = !favour_i_r;
        end else begin
            pick_d = d_req;
        end
    end

    // Pointer: after a D grant favour I next time, and vice versa.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            favour_i_r <= 1'b0;
        end else if (grant) begin
            favour_i_r <= pick_d;
        end else begin
            favour_i_r <= favour_i_r;
        end
    end
`else
    // Winner select: D always beats I.
    always_comb begin
        pick_d = d_req;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one SRAM-like bus between the instruction fetch port (I) and the
// load/store port (D). Each access runs IDLE -> ADDR -> DATA -> DONE; a
// misaligned D access jumps straight from IDLE to DONE with d_err set and
// never touches the bus. Only one transaction is outstanding at a time.
// Ports:
//   clk, resetn                       clock, async active-low reset
//   i_req/i_addr -> i_done/i_rdata    fetch request and completion
//   d_req/d_wr/d_size/d_sel/d_addr/d_wdata -> d_done/d_err/d_rdata
//   bus_req/bus_wr/bus_size/bus_addr/bus_wdata/bus_wstrb   bus request side
//   bus_addr_ok/bus_data_ok/bus_rdata                      bus response side
// Build option MEM_ARB_RR_EN selects round-robin arbitration on simultaneous
// requests (see mem_arbiter_arb_pick); default is fixed D-over-I priority.
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [1:0]        d_size,
    input  logic [3:0]        d_sel,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic              d_err,
    output logic [DATA_W-1:0] d_rdata,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [3:0]        bus_wstrb,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata
);

    arb_state_e        state_r;
    logic              own_d_r;
    logic              own_wr_r;
    logic [1:0]        own_size_r;
    logic [ADDR_W-1:0] own_addr_r;
    logic [DATA_W-1:0] own_wdata_r;
    logic [3:0]        own_strb_r;
    logic              bus_req_r;
    logic              i_done_r;
    logic              d_done_r;
    logic              d_err_r;
    logic [DATA_W-1:0] i_rdata_r;
    logic [DATA_W-1:0] d_rdata_r;

    logic              grant_s;
    logic              pick_d_s;
    logic              misalign_s;
    logic              finish_s;

    assign grant_s    = (state_r == ST_IDLE) && (i_req || d_req);
    assign misalign_s = is_misaligned(d_size, d_addr[1:0]);
    // Data phase completes either in DATA, or in ADDR when the slave accepts
    // the address and returns data in the same cycle.
    assign finish_s   = bus_data_ok &&
                        ((state_r == ST_DATA) || ((state_r == ST_ADDR) && bus_addr_ok));

    mem_arbiter_arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
        .clk    (clk),
        .resetn (resetn),
        .grant  (grant_s),
`endif
        .i_req  (i_req),
        .d_req  (d_req),
        .pick_d (pick_d_s)
    );

    // Arbiter FSM with owner registers and registered completion outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            own_d_r     <= 1'b0;
            own_wr_r    <= 1'b0;
            own_size_r  <= 2'b00;
            own_addr_r  <= {ADDR_W{1'b0}};
            own_wdata_r <= {DATA_W{1'b0}};
            own_strb_r  <= 4'b0000;
            bus_req_r   <= 1'b0;
            i_done_r    <= 1'b0;
            d_done_r    <= 1'b0;
            d_err_r     <= 1'b0;
            i_rdata_r   <= {DATA_W{1'b0}};
            d_rdata_r   <= {DATA_W{1'b0}};
        end else begin
            // Completion flags are single-cycle pulses.
            i_done_r <= 1'b0;
            d_done_r <= 1'b0;
            d_err_r  <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    if (grant_s && pick_d_s) begin
                        own_d_r     <= 1'b1;
                        own_wr_r    <= d_wr;
                        own_size_r  <= d_size;
                        own_addr_r  <= d_addr;
                        own_wdata_r <= d_wdata;
                        own_strb_r  <= d_wr ? d_sel : 4'b0000;
                        if (misalign_s) begin
                            state_r  <= ST_DONE;
                            d_done_r <= 1'b1;
                            d_err_r  <= 1'b1;
                        end else begin
                            state_r   <= ST_ADDR;
                            bus_req_r <= 1'b1;
                        end
                    end else if (grant_s) begin
                        own_d_r     <= 1'b0;
                        own_wr_r    <= 1'b0;
                        own_size_r  <= SIZE_W;
                        own_addr_r  <= i_addr;
                        own_wdata_r <= {DATA_W{1'b0}};
                        own_strb_r  <= 4'b0000;
                        state_r     <= ST_ADDR;
                        bus_req_r   <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ADDR: begin
                    if (bus_addr_ok) begin
                        bus_req_r <= 1'b0;
                        state_r   <= bus_data_ok ? ST_DONE : ST_DATA;
                    end else begin
                        state_r <= ST_ADDR;
                    end
                end
                ST_DATA: begin
                    state_r <= bus_data_ok ? ST_DONE : ST_DATA;
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    bus_req_r <= 1'b0;
                end
            endcase

            // Bus completion: pulse owner's done, capture read data for loads/fetches.
            if (finish_s) begin
                i_done_r <= !own_d_r;
                d_done_r <= own_d_r;
                if (!own_wr_r && own_d_r) begin
                    d_rdata_r <= bus_rdata;
                end
                if (!own_wr_r && !own_d_r) begin
                    i_rdata_r <= bus_rdata;
                end
            end
        end
    end

    assign i_done    = i_done_r;
    assign i_rdata   = i_rdata_r;
    assign d_done    = d_done_r;
    assign d_err     = d_err_r;
    assign d_rdata   = d_rdata_r;
    assign bus_req   = bus_req_r;
    assign bus_wr    = own_wr_r;
    assign bus_size  = own_size_r;
    assign bus_addr  = own_addr_r;
    assign bus_wdata = own_wdata_r;
    assign bus_wstrb = own_strb_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter: directed scenarios followed by
// randomized concurrent I and D traffic against a randomly stalling slave.
// Expected responses are queued at issue time from a word-memory reference
// model; a negedge monitor pops and compares on every done pulse.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int LIMIT = 200;

    logic          clk = 1'b0;
    logic          resetn;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_done;
    logic [DW-1:0] i_rdata;
    logic          d_req;
    logic          d_wr;
    logic [1:0]    d_size;
    logic [3:0]    d_sel;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_done;
    logic          d_err;
    logic [DW-1:0] d_rdata;
    logic          bus_req;
    logic          bus_wr;
    logic [1:0]    bus_size;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic [3:0]    bus_wstrb;
    logic          bus_addr_ok;
    logic          bus_data_ok;
    logic [DW-1:0] bus_rdata;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .resetn(resetn),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_sel(d_sel),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_done(d_done), .d_err(d_err),
        .d_rdata(d_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [logic [29:0]];
    logic [31:0] slv_mem [logic [29:0]];

    function automatic logic [31:0] init_word(input logic [29:0] w);
        return ({2'b00, w} * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : init_word(a[31:2]);
    endfunction

    function automatic logic [31:0] slv_rd(input logic [31:0] a);
        return slv_mem.exists(a[31:2]) ? slv_mem[a[31:2]] : init_word(a[31:2]);
    endfunction

    typedef struct { logic err; logic [31:0] rdata; } dexp_t;
    logic [31:0] i_exp_q [$];
    dexp_t       d_exp_q [$];
    logic [31:0] last_d_m = 32'h0;

    // requester bookkeeping seen by the slave
    bit          i_pend = 1'b0, d_pend = 1'b0;
    logic [31:0] cur_i_addr, cur_d_addr, cur_d_wdata;
    logic        cur_d_wr;
    logic [1:0]  cur_d_size;
    logic [3:0]  cur_d_sel;

    int served_q [$];
    int done_order [$];
    int bus_req_cycles = 0, i_done_cnt = 0, d_done_cnt = 0;

    // slave configuration
    int s_aw = 0, s_dw = 0;
    bit s_same = 1'b0, s_rand = 1'b0;

    task automatic i_access(input logic [31:0] addr, output int lat);
        int n;
        n = 0;
        @(posedge clk); #1;
        i_exp_q.push_back(ref_rd(addr));
        cur_i_addr = addr; i_pend = 1'b1;
        i_req = 1'b1; i_addr = addr;
        do begin @(negedge clk); n++; end while (!i_done && n < LIMIT);
        if (!i_done) check("i_timeout", i_done, 1'b1);
        i_pend = 1'b0; lat = n;
        @(posedge clk); #1;
        i_req = 1'b0;
    endtask

    task automatic d_access(input logic wr, input logic [1:0] size, input logic [3:0] sel,
                            input logic [31:0] addr, input logic [31:0] wdata, output int lat);
        int n;
        dexp_t e;
        logic [31:0] w;
        bit misal;
        n = 0;
        @(posedge clk); #1;
        misal = (addr % (32'd1 << size)) != 32'd0;
        e.err = misal;
        if (!misal && wr) begin
            w = ref_rd(addr);
            for (int b = 0; b < 4; b++) if (sel[b]) w[8*b +: 8] = wdata[8*b +: 8];
            ref_mem[addr[31:2]] = w;
        end else if (!misal) begin
            last_d_m = ref_rd(addr);
        end
        e.rdata = last_d_m;
        d_exp_q.push_back(e);
        cur_d_wr = wr; cur_d_size = size; cur_d_sel = sel; cur_d_addr = addr; cur_d_wdata = wdata;
        d_pend = 1'b1;
        d_req = 1'b1; d_wr = wr; d_size = size; d_sel = sel; d_addr = addr; d_wdata = wdata;
        do begin @(negedge clk); n++; end while (!d_done && n < LIMIT);
        if (!d_done) check("d_timeout", d_done, 1'b1);
        d_pend = 1'b0; lat = n;
        @(posedge clk); #1;
        d_req = 1'b0;
    endtask

    // Monitor: compare every completion against the expected queues.
    always @(negedge clk) begin : monitor
        logic [31:0] ie;
        dexp_t de;
        if (resetn) begin
            if (bus_req) bus_req_cycles++;
            if (i_done && d_done) check("single_owner_done", {i_done, d_done}, 2'b10);
            if (i_done) begin
                i_done_cnt++;
                done_order.push_back(0);
                check("i_done_expected", i_exp_q.size() != 0, 1'b1);
                if (i_exp_q.size() != 0) begin
                    ie = i_exp_q.pop_front();
                    check("i_rdata", i_rdata, ie);
                end
            end
            if (d_done) begin
                d_done_cnt++;
                done_order.push_back(1);
                check("d_done_expected", d_exp_q.size() != 0, 1'b1);
                if (d_exp_q.size() != 0) begin
                    de = d_exp_q.pop_front();
                    check("d_err", d_err, de.err);
                    check("d_rdata", d_rdata, de.rdata);
                end
            end
        end
    end

    // Slave: accepts addresses/data with configurable or random stalls.
    logic [31:0] rec_addr, rec_wdata;
    logic        rec_wr;
    logic [1:0]  rec_size;
    logic [3:0]  rec_strb;
    int          s_phase = 0, s_wait = 0, tr_aw = 0, tr_dw = 0;
    bit          s_first = 1'b1, tr_same = 1'b0;

    task automatic slave_data();
        bus_data_ok = 1'b1;
        if (rec_wr) begin
            logic [31:0] w;
            w = slv_rd(rec_addr);
            for (int b = 0; b < 4; b++) if (rec_strb[b]) w[8*b +: 8] = rec_wdata[8*b +: 8];
            slv_mem[rec_addr[31:2]] = w;
        end else begin
            bus_rdata = slv_rd(rec_addr);
        end
    endtask

    initial begin : slave
        bit m_i, m_d;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
        forever begin
            @(posedge clk); #1;
            bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = $urandom;
            if (!resetn) begin
                s_phase = 0; s_wait = 0; s_first = 1'b1;
            end else if (s_phase == 0) begin
                if (bus_req) begin
                    if (s_first) begin
                        rec_addr = bus_addr; rec_wdata = bus_wdata; rec_wr = bus_wr;
                        rec_size = bus_size; rec_strb = bus_wstrb;
                        m_i = i_pend && !bus_wr && bus_size == 2'b10 && bus_wstrb == 4'b0000
                              && bus_addr == cur_i_addr;
                        m_d = d_pend && bus_wr == cur_d_wr && bus_size == cur_d_size
                              && bus_addr == cur_d_addr
                              && bus_wstrb == (cur_d_wr ? cur_d_sel : 4'b0000)
                              && (!cur_d_wr || bus_wdata == cur_d_wdata);
                        check("bus_fields_match_request", m_i || m_d, 1'b1);
                        served_q.push_back(m_d ? 1 : 0);
                        if (s_rand) begin
                            tr_aw = $urandom_range(0, 3); tr_dw = $urandom_range(0, 3);
                            tr_same = ($urandom_range(0, 3) == 0);
                        end else begin
                            tr_aw = s_aw; tr_dw = s_dw; tr_same = s_same;
                        end
                        s_first = 1'b0; s_wait = 0;
                    end else begin
                        check("bus_addr_stable", bus_addr, rec_addr);
                        check("bus_ctl_stable", {bus_wr, bus_size, bus_wstrb, bus_wdata},
                              {rec_wr, rec_size, rec_strb, rec_wdata});
                    end
                    if (s_wait < tr_aw) begin
                        s_wait++;
                        if (s_rand) bus_data_ok = 1'($urandom_range(0, 1));
                    end else begin
                        bus_addr_ok = 1'b1; s_first = 1'b1; s_wait = 0;
                        if (tr_same) slave_data();
                        else s_phase = 1;
                    end
                end
            end else begin
                if (s_wait < tr_dw) s_wait++;
                else begin slave_data(); s_phase = 0; s_wait = 0; end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        int lat, lat2, b0, id0, dd0;
        resetn = 1'b1;
        i_req = 1'b0; i_addr = 32'h0;
        d_req = 1'b0; d_wr = 1'b0; d_size = 2'b00; d_sel = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
        #1 resetn = 1'b0;
        #1;
        check("reset_outputs_zero", |{i_done, i_rdata, d_done, d_err, d_rdata, bus_req, bus_wr,
                                      bus_size, bus_addr, bus_wdata, bus_wstrb}, 1'b0);
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        // zero-wait fetch
        ref_mem[30'h10] = 32'h2408_0005; slv_mem[30'h10] = 32'h2408_0005;
        s_aw = 0; s_dw = 0; s_same = 1'b0;
        b0 = bus_req_cycles;
        i_access(32'h0000_0040, lat);
        check("fetch_latency", lat, 4);
        check("fetch_bus_cycles", bus_req_cycles - b0, 1);
        check("fetch_rdata_held", i_rdata, 32'h2408_0005);
        @(negedge clk);
        check("i_done_one_cycle", i_done, 1'b0);

        // misaligned half load: no bus cycle, done one cycle after sampling
        b0 = bus_req_cycles;
        d_access(1'b0, 2'b01, 4'b0011, 32'h0000_0011, 32'h0, lat);
        check("misalign_latency", lat, 2);
        check("misalign_no_bus", bus_req_cycles - b0, 0);

        // simultaneous requests
        served_q.delete(); done_order.delete();
        fork
            i_access(32'h0000_0040, lat);
            d_access(1'b1, 2'b00, 4'b1000, 32'h0000_0103, 32'hABAB_ABAB, lat2);
        join
        check("simul_served_count", served_q.size(), 2);
        check("simul_done_count", done_order.size(), 2);
`ifdef MEM_ARB_RR_EN
        if (served_q.size() == 2) check("simul_order", {served_q[0][0], served_q[1][0]}, 2'b01);
        if (done_order.size() == 2) check("simul_done_order", {done_order[0][0], done_order[1][0]}, 2'b01);
`else
        if (served_q.size() == 2) check("simul_order", {served_q[0][0], served_q[1][0]}, 2'b10);
        if (done_order.size() == 2) check("simul_done_order", {done_order[0][0], done_order[1][0]}, 2'b10);
`endif

        // stalling slave
        ref_mem[32'h0001_0100 >> 2] = 32'hDEAD_BEEF; slv_mem[32'h0001_0100 >> 2] = 32'hDEAD_BEEF;
        s_aw = 4; s_dw = 3;
        b0 = bus_req_cycles; dd0 = d_done_cnt;
        d_access(1'b0, 2'b10, 4'hF, 32'h0001_0100, 32'h0, lat);
        check("stall_latency", lat, 11);
        check("stall_bus_cycles", bus_req_cycles - b0, 5);
        check("stall_single_done", d_done_cnt - dd0, 1);
        check("stall_rdata", d_rdata, 32'hDEAD_BEEF);

        // addr_ok and data_ok together
        s_aw = 0; s_dw = 0; s_same = 1'b1;
        b0 = bus_req_cycles;
        i_access(32'h0000_0044, lat);
        check("same_cycle_latency", lat, 3);
        check("same_cycle_bus_cycles", bus_req_cycles - b0, 1);
        s_same = 1'b0;

        // reset in DATA
        s_aw = 0; s_dw = 50;
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 32'h0000_0080; cur_i_addr = 32'h0000_0080; i_pend = 1'b1;
        repeat (4) @(posedge clk);
        check("pre_reset_in_data", {bus_req, i_done}, 2'b00);
        id0 = i_done_cnt; dd0 = d_done_cnt;
        #3 resetn = 1'b0;
        #1;
        check("midreset_outputs_zero", |{i_done, i_rdata, d_done, d_err, d_rdata, bus_req, bus_wr,
                                         bus_size, bus_addr, bus_wdata, bus_wstrb}, 1'b0);
        i_req = 1'b0; i_pend = 1'b0;
        i_exp_q.delete(); d_exp_q.delete(); last_d_m = 32'h0;
        @(posedge clk); #3 resetn = 1'b1;
        repeat (5) @(negedge clk);
        check("no_done_after_reset", {i_done_cnt - id0, d_done_cnt - dd0}, 64'h0);
        s_dw = 0;
        i_access(32'h0000_0080, lat);
        check("post_reset_fetch_latency", lat, 4);

        // randomized concurrent traffic
        s_rand = 1'b1;
        fork
            begin
                int li;
                for (int k = 0; k < 40; k++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    i_access({20'h0, 10'($urandom_range(0, 1023)), 2'b00}, li);
                end
            end
            begin
                int ld;
                for (int k = 0; k < 40; k++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    d_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                             4'($urandom_range(1, 15)),
                             32'h0001_0000 + 32'($urandom_range(0, 63)), $urandom, ld);
                end
            end
        join
        repeat (10) @(negedge clk);
        check("i_queue_drained", i_exp_q.size(), 0);
        check("d_queue_drained", d_exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one SRAM-like memory bus between the instruction-fetch port (I) and the load/store port (D) of the pipeline.
- Sequences each access: grant, address phase, data phase, completion pulse.
- Registers the read data and returns it to the requester.
- Flags misaligned D accesses without issuing a bus cycle. Sits between the pipeline memory stages and the external memory interface.

Parameters:
ADDR_W, 32, address width of requesters and bus
DATA_W, 32, data width of requesters and bus

Ports:
clk  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
i_req  input  1  instruction fetch request, held until i_done
i_addr  input  ADDR_W  fetch address, word-aligned
i_done  output  1  one-cycle completion pulse for I
i_rdata  output  DATA_W  fetched word, valid with i_done, held until next I completion
d_req  input  1  data request, held until d_done
d_wr  input  1  1=store, 0=load
d_size  input  2  00 byte, 01 half, 10 word
d_sel  input  4  byte-lane enables for stores
d_addr  input  ADDR_W  data address
d_wdata  input  DATA_W  store data, already lane-replicated
d_done  output  1  one-cycle completion pulse for D
d_err  output  1  misalignment flag, valid with d_done
d_rdata  output  DATA_W  raw loaded word, valid with d_done, held until next D completion
bus_req  output  1  bus request
bus_wr  output  1  bus write
bus_size  output  2  bus access size
bus_addr  output  ADDR_W  bus address
bus_wdata  output  DATA_W  bus write data
bus_wstrb  output  4  byte strobes: d_sel on store, 0000 on load or fetch
bus_addr_ok  input  1  address phase accepted
bus_data_ok  input  1  data phase complete
bus_rdata  input  DATA_W  read data, valid with bus_data_ok

Behaviour:
- Reset (async, resetn=0): state IDLE; all outputs 0, including i_rdata, d_rdata and the round-robin pointer.
- States: IDLE, ADDR, DATA, DONE. Encoding is 2-bit.
- IDLE:
  - Samples i_req and d_req.
  - If neither is asserted, stays in IDLE.
  - Otherwise the arbiter picks a winner and latches that requester's wr/size/addr/wdata/strb into owner registers.
  - Fixed priority: D wins over I.
  - I requests always latch as size=10, wr=0.
  - If D wins and is misaligned (half with addr[0]=1, or word with addr[1:0]!=00), no bus cycle is issued: go to DONE with err set.
  - Otherwise go to ADDR.
- ADDR:
  - bus_req=1; bus_* driven from the owner registers, stable while in ADDR.
  - bus_addr_ok=1 and bus_data_ok=0: go to DATA.
  - bus_addr_ok=1 and bus_data_ok=1: capture bus_rdata, go to DONE.
  - bus_data_ok without bus_addr_ok is ignored.
- DATA:
  - bus_req=0.
  - Wait for bus_data_ok, then capture bus_rdata into the owner's rdata register (stores capture nothing) and go to DONE.
  - No timeout.
- DONE:
  - Owner's done pulses for exactly 1 cycle. d_err=1 only for a misaligned access.
  - Go to IDLE.
  - Requests present in DONE are not sampled.
- Latency: a fetch with zero-wait memory (addr_ok in the first ADDR cycle, data_ok the next cycle) has i_done 3 cycles after i_req is sampled in IDLE. A misaligned D access has d_done 1 cycle after sampling.
- Requester rules:
  - Requester must keep req and its fields stable until done.
  - Requester must drop req, or present a new access, in the cycle after done. A still-asserted req in IDLE is treated as a new access.
- Only one outstanding transaction; the non-owner waits, done stays 0.
- Reset mid-transaction abandons it; no done pulse is produced. The memory side is reset by the same resetn.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration on simultaneous requests. A 1-bit pointer favours the requester not granted last; it updates on each grant.
- Undefined: fixed D-over-I priority and no pointer flop.
- Single-requester behaviour is identical in both builds.

Decomposition:
- defines.vh: size codes SIZE_B=2'b00, SIZE_H=2'b01, SIZE_W=2'b10, and the arbiter state codes.
- Sub-module arb_pick: combinational winner select from i_req, d_req and the pointer, plus the pointer register under MEM_ARB_RR_EN.
- The FSM, owner registers and misalignment check stay in mem_arbiter.

Test Plan:
- I-only fetch, i_addr=0x0000_0040, addr_ok on the first ADDR cycle, data_ok+rdata=0x2408_0005 the next cycle -> bus_wstrb=0000, bus_size=10; i_done=1 for one cycle 3 cycles after request; i_rdata=0x2408_0005.
- Simultaneous i_req and d_req (store, size=00, addr=0x103, sel=1000, wdata=0xABABABAB) -> bus shows D first with bus_wstrb=1000, bus_wr=1; d_done=1; then I served and i_done=1. With MEM_ARB_RR_EN and the pointer favouring I: I is served first.
- D load half at addr 0x0000_0011 -> no bus_req ever; d_done=1 and d_err=1 one cycle after sampling.
- Slave stalls addr_ok 4 cycles and data_ok 3 further cycles -> bus_req high exactly 5 cycles with bus_addr/bus_size constant; a single d_done; d_rdata=0xDEADBEEF.
- addr_ok and data_ok in the same ADDR cycle -> DATA skipped; done 1 cycle later with the correct rdata.
- resetn pulsed low while in DATA -> all outputs 0 immediately; no done pulse; a subsequent fetch completes normally.
